// File: rtl/apb_master_queued_pkg.sv
// Shared types for the queued APB master: FSM state encoding and the
// command FIFO entry layout helper.
package apb_master_queued_pkg;

  // Bus phase of the master
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // FIFO entry layout, MSB first: {rw, addr, wdata}
  function automatic int unsigned cmd_width(input int unsigned aw, input int unsigned dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/apb_master_queued_cmd_fifo.sv
// Synchronous command FIFO with wrapping pointers and registered full/empty.
// A write is accepted when full if a read happens in the same cycle.
// Ports: clk/rst_n; wr_en_i/wr_data_i push; rd_en_i pop;
//        head_c oldest entry (combinational read); full_o/empty_o status.
module apb_master_queued_cmd_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] head_c,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q;
  logic             wr_ok, rd_ok;

  assign rd_ok   = rd_en_i && !empty_q;
  assign wr_ok   = wr_en_i && (!full_q || rd_ok);
  assign count_d = count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);

  // Pointers, occupancy and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage needs no reset; occupancy tracking guards reads
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign head_c  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/apb_master_queued.sv
// Queued APB master: buffers CPU requests in a command FIFO and runs them as
// SETUP/ACCESS transfers on NUM_SLAVES address-decoded slaves, with wait
// states, PSLVERR reporting, an ACCESS timeout and back-to-back transfers.
// Ports: P_clk/P_reset_n; request side start_transfer/rw/addr/wdata, busy;
//        response side valid/resp_write/rdata/err; APB side P_addr/P_wdata/
//        P_write/P_sel/P_enable out, P_rdata/P_ready/P_slverr in.
module apb_master_queued
  import apb_master_queued_pkg::*;
#(
  parameter int unsigned ADDR_width  = 8,
  parameter int unsigned DATA_width  = 8,
  parameter int unsigned NUM_SLAVES  = 4,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                             P_clk,
  input  logic                             P_reset_n,
  input  logic                             start_transfer,
  input  logic                             rw,
  input  logic [ADDR_width-1:0]            addr,
  input  logic [DATA_width-1:0]            wdata,
  output logic                             busy,
  output logic                             valid,
  output logic                             resp_write,
  output logic [DATA_width-1:0]            rdata,
  output logic                             err,
  output logic [ADDR_width-1:0]            P_addr,
  output logic [DATA_width-1:0]            P_wdata,
  output logic                             P_write,
  output logic [NUM_SLAVES-1:0]            P_sel,
  output logic                             P_enable,
  input  logic [NUM_SLAVES*DATA_width-1:0] P_rdata,
  input  logic [NUM_SLAVES-1:0]            P_ready,
  input  logic [NUM_SLAVES-1:0]            P_slverr
);

  localparam int unsigned SEL_W = $clog2(NUM_SLAVES);
  localparam int unsigned CMD_W = cmd_width(ADDR_width, DATA_width);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

  apb_state_e              state_q, state_d;
  logic [ADDR_width-1:0]   addr_q, addr_d;
  logic [DATA_width-1:0]   wdata_q, wdata_d;
  logic                    write_q, write_d;
  logic [NUM_SLAVES-1:0]   sel_q, sel_d;
  logic                    enable_q, enable_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    valid_q, valid_d;
  logic                    resp_write_q, resp_write_d;
  logic [DATA_width-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty, do_load;
  logic [CMD_W-1:0]        fifo_head;
  logic                    head_write;
  logic [ADDR_width-1:0]   head_addr;
  logic [DATA_width-1:0]   head_wdata;
  logic                    ready_sel, slverr_sel;
  logic [DATA_width-1:0]   rdata_sel;

  assign fifo_push = start_transfer && !fifo_full;

  apb_master_queued_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk       (P_clk),
    .rst_n     (P_reset_n),
    .wr_en_i   (fifo_push),
    .wr_data_i ({rw, addr, wdata}),
    .rd_en_i   (fifo_pop),
    .head_c    (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign head_write = fifo_head[CMD_W-1];
  assign head_addr  = fifo_head[DATA_width +: ADDR_width];
  assign head_wdata = fifo_head[DATA_width-1:0];

  // Observe only the slave selected by the one-hot P_sel register
  always_comb begin : slave_mux
    ready_sel  = 1'b0;
    slverr_sel = 1'b0;
    rdata_sel  = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        ready_sel  = ready_sel  | P_ready[i];
        slverr_sel = slverr_sel | P_slverr[i];
        rdata_sel  = rdata_sel  | P_rdata[i*DATA_width +: DATA_width];
      end
    end
  end

  // Next state, bus phase and response values
  always_comb begin : next_state
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    sel_d        = sel_q;
    enable_d     = enable_q;
    cnt_d        = cnt_q;
    valid_d      = 1'b0;
    resp_write_d = resp_write_q;
    rdata_d      = rdata_q;
    err_d        = 1'b0;
    fifo_pop     = 1'b0;
    do_load      = 1'b0;

    case (state_q)
      ST_IDLE: do_load = !fifo_empty;
      ST_SETUP: begin
        state_d  = ST_ACCESS;
        enable_d = 1'b1;
        cnt_d    = '0;
      end
      ST_ACCESS: begin
        if (ready_sel) begin
          valid_d = 1'b1;
          err_d   = slverr_sel;
          if (!write_q) rdata_d = rdata_sel;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          valid_d = 1'b1;
          err_d   = 1'b1;
          if (!write_q) rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (valid_d) begin
          resp_write_d = write_q;
          // Chain straight into the next SETUP when work is queued
          if (!fifo_empty) begin
            do_load = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            sel_d    = '0;
            enable_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_load) begin
      fifo_pop = 1'b1;
      addr_d   = head_addr;
      wdata_d  = head_wdata;
      write_d  = head_write;
      sel_d    = '0;
      sel_d[head_addr[ADDR_width-1 -: SEL_W]] = 1'b1;
      enable_d = 1'b0;
      state_d  = ST_SETUP;
    end
  end

  // State and output registers
  always_ff @(posedge P_clk or negedge P_reset_n) begin
    if (!P_reset_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      sel_q        <= '0;
      enable_q     <= 1'b0;
      cnt_q        <= '0;
      valid_q      <= 1'b0;
      resp_write_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      sel_q        <= sel_d;
      enable_q     <= enable_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      resp_write_q <= resp_write_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign busy       = fifo_full;
  assign valid      = valid_q;
  assign resp_write = resp_write_q;
  assign rdata      = rdata_q;
  assign err        = err_q;
  assign P_addr     = addr_q;
  assign P_wdata    = wdata_q;
  assign P_write    = write_q;
  assign P_sel      = sel_q;
  assign P_enable   = enable_q;

endmodule
